shift_add_mult: RTL and testbench

Iterative unsigned shift-and-add multiplier for the gate-level ALU. It sits downstream of the parameterised ripple adder and consumes that adder's sum and carry-out once per clock to build a 2*WIDTH product. A start/busy/done handshake lets the ALU control FSM issue one multiply at a time. It trades WIDTH cycles of latency for a single WIDTH-bit adder.

---
 rtl/shift_add_mult_pkg.sv | 17 +
 rtl/param_adder.sv | 14 +
 rtl/shift_add_mult.sv | 108 ++++++++++
 tb/tb_shift_add_mult.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared state encoding and sizing helpers for the shift-and-add multiplier.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x != 0; x = x >> 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/param_adder.sv
// Combinational WIDTH-bit ripple adder with carry-in and carry-out.
module param_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  assign {o_carry, o_sum} = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b) + (WIDTH+1)'(i_carry);

endmodule

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier: one partial-product add per
// clock through a single WIDTH-bit adder, start/busy/done handshake.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_op1,
  input  logic [WIDTH-1:0]   i_op2,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned CNT_W = clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand, mcand_nx;
  logic [WIDTH-1:0] acc_hi, acc_hi_nx;
  logic [WIDTH-1:0] acc_lo, acc_lo_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             busy_nx, done_nx;
  logic [PW-1:0]    product_nx;

  logic [WIDTH-1:0] add_sum;
  logic             add_c;
  logic [WIDTH-1:0] pp_sum;
  logic             pp_c;

  param_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a     (acc_hi),
    .i_b     (mcand),
    .i_carry (1'b0),
    .o_sum   (add_sum),
    .o_carry (add_c)
  );

  // Partial product: add the multiplicand only when the current multiplier bit is set
  assign pp_sum = acc_lo[0] ? add_sum : acc_hi;
  assign pp_c   = acc_lo[0] & add_c;

  always_comb begin
    state_nx   = state;
    mcand_nx   = mcand;
    acc_hi_nx  = acc_hi;
    acc_lo_nx  = acc_lo;
    cnt_nx     = cnt;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    product_nx = o_product;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          mcand_nx  = i_op1;
          acc_lo_nx = i_op2;
          acc_hi_nx = '0;
          cnt_nx    = '0;
          busy_nx   = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Carry lands in the top bit of the shifted high half, so nothing overflows
        acc_hi_nx = {pp_c, pp_sum[WIDTH-1:1]};
        acc_lo_nx = {pp_sum[0], acc_lo[WIDTH-1:1]};
        cnt_nx    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nx = ST_DONE;
        end else begin
          busy_nx = 1'b1;
        end
      end
      ST_DONE: begin
        product_nx = {acc_hi, acc_lo};
        done_nx    = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_product <= '0;
    end else begin
      state     <= state_nx;
      mcand     <= mcand_nx;
      acc_hi    <= acc_hi_nx;
      acc_lo    <= acc_lo_nx;
      cnt       <= cnt_nx;
      o_busy    <= busy_nx;
      o_done    <= done_nx;
      o_product <= product_nx;
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult at WIDTH=4 and WIDTH=8.
module tb_shift_add_mult;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] prod4;
  logic       start8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] prod8;

  int total = 0;
  int bad   = 0;

  shift_add_mult #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_op1(a4), .i_op2(b4),
    .o_busy(busy4), .o_done(done4), .o_product(prod4)
  );

  shift_add_mult #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_op1(a8), .i_op2(b8),
    .o_busy(busy8), .o_done(done8), .o_product(prod8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=4 multiply; optionally pokes a second start mid-run, which must be ignored
  task automatic run4(input string tag, input int a, input int b, input bit poke);
    int k, busy_cnt, dones;
    start4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
    step();
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    k = 0; busy_cnt = 0;
    while (!done4 && k < 20) begin
      if (busy4) busy_cnt++;
      if (poke && k == 2) begin start4 = 1'b1; a4 = 4'd3; b4 = 4'd3; end
      else start4 = 1'b0;
      step();
      k++;
    end
    start4 = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'd5);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    chk({tag, "_product"}, 32'(prod4), 32'(a * b));
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done4) dones++;
    end
    chk({tag, "_single_done"}, 32'(dones), 32'd0);
    chk({tag, "_hold"}, 32'(prod4), 32'(a * b));
  endtask

  task automatic run8(input string tag, input int a, input int b);
    int k;
    start8 = 1'b1; a8 = 8'(a); b8 = 8'(b);
    step();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    k = 0;
    while (!done8 && k < 30) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'd9);
    chk({tag, "_product"}, 32'(prod8), 32'(a * b));
    step();
    chk({tag, "_done_fall"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int k, gap, a, b;
    bit held_ok;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    step(); step();
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_product", 32'(prod4), 32'd0);
    chk("rst_product8", 32'(prod8), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_product", 32'(prod4), 32'd0);

    run4("m13x11", 13, 11, 1'b0);
    chk("m13x11_hex", 32'(prod4), 32'h8F);
    run4("m15x15", 15, 15, 1'b0);
    chk("m15x15_hex", 32'(prod4), 32'hE1);
    run4("m0x9", 0, 9, 1'b0);
    run4("m7x6_poke", 7, 6, 1'b1);

    // Reset during the run aborts everything at once
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd5;
    step();
    start4 = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_done", 32'(done4), 32'd0);
    chk("abort_product", 32'(prod4), 32'd0);
    k = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done4) k++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done4) k++;
    end
    chk("abort_no_done", 32'(k), 32'd0);
    chk("abort_product_stable", 32'(prod4), 32'd0);
    run4("m2x3", 2, 3, 1'b0);

    // Back-to-back with start held high
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    step();
    a4 = 4'd10; b4 = 4'd12;
    k = 0;
    while (!done4 && k < 20) begin step(); k++; end
    chk("b2b_first_latency", 32'(k), 32'd5);
    chk("b2b_first_product", 32'(prod4), 32'd81);
    gap = 0; held_ok = 1'b1;
    step(); gap++;
    while (!done4 && gap < 20) begin
      if (prod4 !== 8'd81) held_ok = 1'b0;
      step(); gap++;
    end
    start4 = 1'b0;
    chk("b2b_gap", 32'(gap), 32'd6);
    chk("b2b_hold81", 32'(held_ok), 32'd1);
    chk("b2b_second_product", 32'(prod4), 32'd120);
    step();

    run8("w8_max", 255, 255);
    chk("w8_max_hex", 32'(prod8), 32'hFE01);
    run8("w8_zero", 0, 200);
    for (int n = 0; n < 1000; n++) begin
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 0));
      run8("w8_rand", a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
